// File: rtl/otter_mem_arbiter.sv
// Shares the Otter's single memory port between instruction fetch and the MEM stage.
// Define OTTER_ARB_TIMEOUT_EN to add a response watchdog that forces an error completion.
module otter_mem_arbiter #(
  parameter int IF_STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  output logic        m_sign,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0]  STARVE_MAX = 4'(IF_STARVE_LIMIT);
  localparam logic [31:0] ERR_WORD   = 32'hDEAD_BEEF;

  if (IF_STARVE_LIMIT < 1 || IF_STARVE_LIMIT > 15 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("otter_mem_arbiter: parameter out of legal range");
  end

  logic [1:0] state;
  logic       owner_if;
  logic [3:0] starve_cnt;
  logic       grant_any;
  logic       grant_if;
  logic       resp_err;
  logic       resp_done;

  // Data wins a tie unless fetch has already been passed over the limit.
  assign grant_any = if_req | d_req;
  assign grant_if  = if_req & (~d_req | (starve_cnt == STARVE_MAX));

`ifdef OTTER_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt;

  // A real response in the limit cycle takes precedence over the timeout.
  assign resp_err = (state == ST_WAIT) & ~m_rvalid & (wd_cnt == WD_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= resp_err;
      if (state != ST_WAIT)
        wd_cnt <= '0;
      else if (!resp_done)
        wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign resp_err = 1'b0;
  assign err      = 1'b0;
`endif

  assign resp_done = (state == ST_WAIT) & (m_rvalid | resp_err);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      owner_if   <= 1'b0;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_size     <= '0;
      m_sign     <= 1'b0;
    end else begin
      // NOTE: acks default low every cycle so they can only ever be a single-cycle pulse.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state    <= ST_REQ;
            m_req    <= 1'b1;
            owner_if <= grant_if;
            if (grant_if) begin
              m_we       <= 1'b0;
              m_addr     <= if_addr;
              m_wdata    <= '0;
              m_size     <= 2'd2;
              m_sign     <= 1'b0;
              starve_cnt <= '0;
            end else begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_size  <= d_size;
              m_sign  <= d_sign;
              if (!if_req)
                starve_cnt <= '0;
              else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ST_REQ: begin
          if (m_ready) begin
            state <= ST_WAIT;
            m_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (resp_done) begin
            state <= ST_DONE;
            if (owner_if) begin
              if_ack   <= 1'b1;
              if_rdata <= resp_err ? ERR_WORD : m_rdata;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= resp_err ? ERR_WORD : m_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Randomized self-checking bench for otter_mem_arbiter against a transaction-level model.
module tb_otter_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_sign = 1'b0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_size;
  logic        m_sign;
  logic        m_ready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: starvation count and last word returned to each requester.
  int          starve = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  otter_mem_arbiter #(.IF_STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sign(d_sign), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_sign(m_sign), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic rand_d();
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_size  = 2'($urandom_range(0, 2));
    d_sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    starve = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    @(negedge CLK);
  endtask

  // One full transaction starting at a negedge in IDLE with at least one request pending.
  // rd: cycles m_ready is held low in REQ; wd: WAIT cycles before m_rvalid.
  task automatic serve(input int rd, input int wd, input logic [31:0] rval,
                       input bit keep_if, input bit keep_d, output bit got_if);
    bit          exp_if;
    logic [67:0] exp_attr;
    exp_if = if_req && (!d_req || starve >= LIMIT);
    if (exp_if) begin
      exp_attr = {1'b0, if_addr, 32'h0, 2'd2, 1'b0};
      starve = 0;
    end else begin
      exp_attr = {d_we, d_addr, d_wdata, d_size, d_sign};
      starve = if_req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    end
    m_ready = 1'($urandom_range(0, 1));
    m_rvalid = 1'($urandom_range(0, 1));
    @(posedge CLK); @(negedge CLK);
    for (int i = 0; i <= rd; i++) begin
      tests_run++;
      if (m_req !== 1'b1) begin
        tests_failed++; $display("FAIL req_m_req: got %b required 1 (cycle %0d)", m_req, i);
      end
      tests_run++;
      if ({m_we, m_addr, m_wdata, m_size, m_sign} !== exp_attr) begin
        tests_failed++;
        $display("FAIL req_attr: got %h required %h", {m_we, m_addr, m_wdata, m_size, m_sign}, exp_attr);
      end
      tests_run++;
      if ({if_ack, d_ack} !== 2'b00) begin
        tests_failed++; $display("FAIL req_ack: got %b required 00", {if_ack, d_ack});
      end
      m_ready  = (i == rd);
      m_rvalid = 1'($urandom_range(0, 1));
      m_rdata  = $urandom;
      if_addr  = $urandom;
      rand_d();
      @(posedge CLK); @(negedge CLK);
    end
    for (int i = 0; i <= wd; i++) begin
      tests_run++;
      if ({m_req, if_ack, d_ack} !== 3'b000) begin
        tests_failed++; $display("FAIL wait_idle: got %b required 000 (cycle %0d)", {m_req, if_ack, d_ack}, i);
      end
      m_ready  = 1'($urandom_range(0, 1));
      m_rvalid = (i == wd);
      m_rdata  = (i == wd) ? rval : $urandom;
      @(posedge CLK); @(negedge CLK);
    end
    got_if = if_ack;
    if (exp_if) exp_if_rdata = rval; else exp_d_rdata = rval;
    tests_run++;
    if ({if_ack, d_ack} !== (exp_if ? 2'b10 : 2'b01)) begin
      tests_failed++;
      $display("FAIL done_ack: got %b required %b", {if_ack, d_ack}, exp_if ? 2'b10 : 2'b01);
    end
    tests_run++;
    if ({if_rdata, d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
      tests_failed++;
      $display("FAIL done_rdata: got %h/%h required %h/%h", if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
    end
    tests_run++;
    if ({err, m_req} !== 2'b00) begin
      tests_failed++; $display("FAIL done_err: got %b required 00", {err, m_req});
    end
    m_ready  = 1'($urandom_range(0, 1));
    m_rvalid = 1'($urandom_range(0, 1));
    if (exp_if) begin
      if_req = keep_if;
      if (keep_if) if_addr = $urandom;
    end else begin
      d_req = keep_d;
      if (keep_d) rand_d();
    end
    @(posedge CLK); @(negedge CLK);
    tests_run++;
    if ({if_ack, d_ack, m_req} !== 3'b000) begin
      tests_failed++; $display("FAIL post_idle: got %b required 000", {if_ack, d_ack, m_req});
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({m_req, if_ack, d_ack, err, m_we, m_size, m_sign, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    do_reset();
    tests_run++;
    if ({m_req, if_ack, d_ack} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_idle: got %b required 000", {m_req, if_ack, d_ack});
    end
  endtask

  task automatic test_single_fetch();
    bit g;
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    serve(0, 0, 32'h0050_0093, 1'b0, 1'b0, g);
    tests_run++;
    if (if_rdata !== 32'h0050_0093) begin
      tests_failed++; $display("FAIL fetch_rdata: got %h required 00500093", if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    bit g;
    do_reset();
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1100_0000; d_wdata = 32'hA5; d_size = 2'd0; d_sign = 1'b0;
    serve(0, 0, $urandom, 1'b1, 1'b0, g);
    tests_run++;
    if (g !== 1'b0) begin
      tests_failed++; $display("FAIL simul_first: got owner_if=%b required 0", g);
    end
    serve(0, 0, $urandom, 1'b0, 1'b0, g);
    tests_run++;
    if (g !== 1'b1) begin
      tests_failed++; $display("FAIL simul_second: got owner_if=%b required 1", g);
    end
  endtask

  task automatic test_starvation();
    bit g;
    bit pattern [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    if_req = 1'b1; if_addr = $urandom;
    d_req = 1'b1; rand_d();
    for (int i = 0; i < 10; i++) begin
      serve(0, 0, $urandom, 1'b1, 1'b1, g);
      tests_run++;
      if (g !== pattern[i]) begin
        tests_failed++; $display("FAIL starve_owner[%0d]: got owner_if=%b required %b", i, g, pattern[i]);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_wait_states();
    bit g;
    do_reset();
    d_req = 1'b1; rand_d(); d_we = 1'b0;
    serve(3, 5, 32'hCAFE_1234, 1'b0, 1'b0, g);
    tests_run++;
    if (d_rdata !== 32'hCAFE_1234) begin
      tests_failed++; $display("FAIL wait_rdata: got %h required cafe1234", d_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    bit g;
    do_reset();
    if_req = 1'b1; if_addr = $urandom;
    serve(0, 0, 32'h1357_9BDF, 1'b0, 1'b0, g);
    d_req = 1'b1; rand_d();
    @(posedge CLK); @(negedge CLK);
    m_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    m_ready = 1'b0;
    #1 RESET = 1'b1;
    d_req = 1'b0;
    #1;
    tests_run++;
    if ({m_req, if_ack, d_ack, err, m_we, m_size, m_sign, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
      tests_failed++; $display("FAIL rst_wait_outputs: got nonzero outputs, required all 0");
    end
    @(negedge CLK);
    RESET = 1'b0;
    starve = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    m_rvalid = 1'b1; m_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      m_rvalid = 1'b0;
      tests_run++;
      if ({m_req, if_ack, d_ack, d_rdata} !== '0) begin
        tests_failed++;
        $display("FAIL rst_late_rvalid: got req/acks %b d_rdata %h required 0", {m_req, if_ack, d_ack}, d_rdata);
      end
    end
    d_req = 1'b1; rand_d();
    serve(1, 1, $urandom, 1'b0, 1'b0, g);
  endtask

`ifdef OTTER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit g;
    int n;
    do_reset();
    d_req = 1'b1; rand_d();
    serve(0, TMO - 1, 32'h2468_ACE0, 1'b0, 1'b0, g);
    d_req = 1'b1; rand_d(); d_we = 1'b0;
    starve = 0;
    @(posedge CLK); @(negedge CLK);
    m_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    m_ready = 1'b0; m_rvalid = 1'b0;
    n = 1;
    while (n < 40) begin
      @(posedge CLK); @(negedge CLK);
      if (d_ack) break;
      n++;
    end
    exp_d_rdata = 32'hDEAD_BEEF;
    tests_run++;
    if (n !== TMO || d_ack !== 1'b1) begin
      tests_failed++; $display("FAIL tmo_cycles: got %0d wait cycles ack=%b required %0d ack=1", n, d_ack, TMO);
    end
    tests_run++;
    if ({err, if_ack, d_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      tests_failed++; $display("FAIL tmo_err: got err=%b if_ack=%b d_rdata=%h required 1 0 deadbeef", err, if_ack, d_rdata);
    end
    d_req = 1'b0;
    @(posedge CLK); @(negedge CLK);
    tests_run++;
    if ({err, d_ack, m_req} !== 3'b000) begin
      tests_failed++; $display("FAIL tmo_idle: got %b required 000", {err, d_ack, m_req});
    end
  endtask
`endif

  task automatic test_random();
    bit g;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin if_req = 1'b1; if_addr = $urandom; end
      if (!d_req && $urandom_range(0, 1) == 1) begin d_req = 1'b1; rand_d(); end
      if (!if_req && !d_req) begin d_req = 1'b1; rand_d(); end
      serve($urandom_range(0, 3), $urandom_range(0, 4), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, g);
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_reset_in_wait();
`ifdef OTTER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the single data/instruction memory port of the pipelined Otter between two requesters: instruction fetch (IF, read-only) and the MEM stage (data load/store, including MMIO).
- Single outstanding transaction. Data-priority arbitration with a bounded IF-starvation counter.
- Per-requester ack pulses, from which the hazard logic derives `if_stall` / `mem_stall`.
- Optional response-timeout watchdog.

Parameters:
- `IF_STARVE_LIMIT`, 4: max consecutive data grants while `if_req` is pending; the next grant is forced to IF. Legal range 1..15.
- `TIMEOUT_CYCLES`, 64: WAIT-state cycles before a forced error completion. Used only with the optional feature. Legal range 2..255.

Ports:
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request, level; held until `if_ack`.
- `if_addr` in 32: fetch byte address.
- `if_ack` out 1: one-cycle pulse, fetch complete.
- `if_rdata` out 32: fetched word; valid when `if_ack`=1.
- `d_req` in 1: data request, level; held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_size` in 2: 0 byte, 1 half, 2 word.
- `d_sign` in 1: 1 = zero-extend (funct3[2]), passed through.
- `d_ack` out 1: one-cycle pulse, data access complete.
- `d_rdata` out 32: load data; valid when `d_ack`=1.
- `m_req` out 1: downstream request.
- `m_we`, `m_addr`[32], `m_wdata`[32], `m_size`[2], `m_sign` out: latched transaction attributes.
- `m_ready` in 1: downstream accepts the request this cycle.
- `m_rvalid` in 1: downstream completion; for stores it is the write acknowledge.
- `m_rdata` in 32: downstream read data; valid when `m_rvalid`=1.
- `err` out 1: pulses with the ack of a timed-out transaction.

Behaviour:
- **Reset (async, immediate):**
  - state=IDLE; all outputs 0, including `m_req`, acks, `rdata` regs and `err`.
  - Starvation counter and watchdog = 0.
  - A `m_rvalid` arriving after a reset mid-transaction is ignored.
- **States:** IDLE, REQ, WAIT, DONE. All outputs are registered.
- **IDLE:**
  - If neither request: stay.
  - If only one request: grant it.
  - If both: grant data, unless `starve_cnt` == `IF_STARVE_LIMIT`, then grant IF.
  - On grant: latch owner and attributes into the `m_*` regs (IF grant: `m_we`=0, `m_size`=2, `m_sign`=0, `m_wdata`=0); go to REQ.
- **`starve_cnt` (4-bit):**
  - Data grant with `if_req`=1: +1, saturating at `IF_STARVE_LIMIT`.
  - Any IF grant, or a data grant with `if_req`=0: cleared.
- **REQ:** `m_req`=1; attributes are stable. When `m_ready`=1, go to WAIT with `m_req`=0 next cycle.
- **WAIT:** `m_req`=0. When `m_rvalid`=1, capture `m_rdata` into the owner's `rdata` reg (stores capture `m_rdata` as returned) and go to DONE.
- **DONE:**
  - Owner's ack=1 for exactly this cycle; the other ack is 0. Go to IDLE.
  - The requester drops `req` combinationally on ack if it has no further work.
  - `req` still high in the following IDLE cycle is a new transaction.
- **Latency:** zero-wait memory (`m_ready`=1 in REQ, `m_rvalid` the first WAIT cycle) gives ack 3 cycles after `req` is sampled. Back-to-back throughput is 1 transaction per 4 cycles.
- **`rdata` hold:** each `rdata` reg holds its value until overwritten by the next transaction of the same owner.
- **Request changes:** a `req`/attribute change while not in IDLE has no effect. Attributes are sampled only at grant.
- **Out-of-state inputs:** `m_rvalid` in IDLE, REQ or DONE is ignored. `m_ready` outside REQ is ignored.

Optional Feature:
- **`OTTER_ARB_TIMEOUT_EN` defined:**
  - A watchdog counts WAIT cycles.
  - If `TIMEOUT_CYCLES` elapse with no `m_rvalid`, go to DONE with owner ack=1, `err`=1, and owner `rdata`=32'hDEADBEEF.
  - The watchdog clears on entering WAIT.
  - If `m_rvalid` arrives in the same cycle the limit is reached, `m_rvalid` wins and `err`=0.
- **Undefined:** no watchdog logic; `err` is tied to 0; WAIT waits indefinitely.

Test Plan:
- **Single fetch:** `if_req`=1, `if_addr`=0x100, zero-wait memory with `m_rdata`=0x00500093 → `m_req` for one cycle with `m_addr`=0x100, `m_size`=2; `if_ack` pulses 3 cycles after `req` with `if_rdata`=0x00500093; `d_ack` stays 0.
- **Simultaneous requests:** `if_req`=`d_req`=1, `d_we`=1, `d_addr`=0x11000000, `d_wdata`=0xA5, `d_size`=0 → data granted first (`m_we`=1, `m_wdata`=0xA5, `m_size`=0), `d_ack`, then IF granted, `if_ack` 4 cycles later.
- **Starvation:** `d_req` held high continuously plus `if_req`=1, `IF_STARVE_LIMIT`=4 → exactly 4 `d_ack`s, then an IF grant, then the counter restarts.
- **Wait states:** `m_ready` low 3 cycles in REQ, `m_rvalid` 5 cycles into WAIT → `m_req` held 4 cycles with constant attributes; ack arrives exactly 1 cycle after `m_rvalid`; `d_rdata` = returned value.
- **Reset in WAIT:** `RESET` pulsed during WAIT, late `m_rvalid`=1 afterwards → all outputs 0 immediately; no ack generated; the next request is served normally.
- **Timeout (`OTTER_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** `m_rvalid` never asserted → after 8 WAIT cycles, `d_ack`=1, `err`=1, `d_rdata`=0xDEADBEEF, state returns to IDLE.
